imem_loader: RTL and testbench

- Byte-stream program loader. It is the writer side of the instruction memory, which the processor's fetch path only reads.
- Receives a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues one write strobe per word to the instruction memory's write port.
- Holds the processor in reset while loading, then releases it.
- Sits between an external byte source (UART receiver, testbench) and the instruction memory / processor top.

---
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// slave: loader view (consumes bytes, drives the memory write port).
// master: environment view (byte source and memory/observer side).
interface imem_loader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [7:0]               byte_i;
    logic                     byte_valid_i;
    logic                     byte_ready_o;
    logic                     mem_we_o;
    logic [ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0]    mem_wdata_o;

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o
    );

    modport master (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream loader for the instruction memory.
// Assembles little-endian 32-bit words, writes one word per WRITE cycle and
// holds the processor in reset while a load is in progress.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (CHK state); without it the last WRITE goes straight to DONE.
//
// state  | meaning
// IDLE   | after reset, waiting for start_i
// LEN_LO | waiting for low length byte
// LEN_HI | waiting for high length byte, then range check
// DATA   | collecting the 4 bytes of the next word
// WRITE  | one-cycle memory write strobe
// CHK    | waiting for checksum byte (checksum build only)
// DONE   | load finished, processor released
// ERROR  | load aborted, processor kept in reset
module imem_loader #(
    parameter int DATA_WIDTH    = 32,   // word assembly below assumes 32
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    imem_loader_if.slave      bus,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [15:0]       words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    // 17 bits so a 16-bit length of 65535 compares correctly against the limit
    localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);

    state_t                   state;
    state_t                   state_nxt;
    logic [15:0]              len_q;
    logic [1:0]               byte_idx;
    logic [23:0]              word_q;
    logic [15:0]              words_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]               xor_q;
`endif

    logic        ready;
    logic        accept;
    logic        start_ok;
    logic        we;
    logic [15:0] len_full;
    logic [15:0] words_inc;

    // ready depends on state only so the source never sees a combinational path back
    assign ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state == S_CHK)
`endif
                   ;
    assign accept    = bus.byte_valid_i & ready;
    assign start_ok  = start_i & ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len_full  = {bus.byte_i, len_q[7:0]};
    assign words_inc = words_q + 16'd1;

    assign bus.byte_ready_o = ready;
    assign bus.mem_we_o     = we;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign words_loaded_o   = words_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        we         = 1'b0;
        busy_o     = 1'b0;
        cpu_hold_o = 1'b0;
        done_o     = 1'b0;
        error_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                busy_o     = 1'b1;
                cpu_hold_o = 1'b1;
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                busy_o     = 1'b1;
                cpu_hold_o = 1'b1;
                if (accept) begin
                    if (len_full == 16'd0)                state_nxt = S_DONE;
                    else if ({1'b0, len_full} > MEM_LIMIT) state_nxt = S_ERROR;
                    else                                   state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                busy_o     = 1'b1;
                cpu_hold_o = 1'b1;
                if (accept && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                we         = 1'b1;
                busy_o     = 1'b1;
                cpu_hold_o = 1'b1;
                if (words_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                busy_o     = 1'b1;
                cpu_hold_o = 1'b1;
                if (accept) state_nxt = (bus.byte_i == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                done_o = 1'b1;
                if (start_ok) state_nxt = S_LEN_LO;
            end
            S_ERROR: begin
                error_o    = 1'b1;
                cpu_hold_o = 1'b1;
                if (start_ok) state_nxt = S_LEN_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Length capture, word assembly, write port registers and word count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            byte_idx <= '0;
            word_q   <= '0;
            words_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else if (start_ok) begin
            len_q    <= '0;
            byte_idx <= '0;
            words_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            case (state)
                S_LEN_LO: if (accept) len_q[7:0]  <= bus.byte_i;
                S_LEN_HI: if (accept) len_q[15:8] <= bus.byte_i;
                S_DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q    <= xor_q ^ bus.byte_i;
`endif
                        case (byte_idx)
                            2'd0: word_q[7:0]   <= bus.byte_i;
                            2'd1: word_q[15:8]  <= bus.byte_i;
                            2'd2: word_q[23:16] <= bus.byte_i;
                            default: begin
                                // 4th byte goes straight into the write register
                                wdata_q <= DATA_WIDTH'({bus.byte_i, word_q});
                                addr_q  <= ADDRESS_WIDTH'({words_q, 2'b00});
                            end
                        endcase
                    end
                end
                S_WRITE: words_q <= words_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and randomized byte streams checked
// against a reference model of the expected memory writes and final status.
module tb_imem_loader;
    localparam int MEM_SIZE = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cpu_hold, busy, done, error;
    logic [15:0] words_loaded;

    imem_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    imem_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .bus            (bus),
        .cpu_hold_o     (cpu_hold),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_cyc[$];

    // record every write strobe; ready must be low while it is up
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.mem_we_o === 1'b1) begin
            cap_addr.push_back(bus.mem_addr_o);
            cap_data.push_back(bus.mem_wdata_o);
            cap_cyc.push_back(cyc);
            total++;
            assert (bus.byte_ready_o === 1'b0) else begin
                bad++;
                $error("FAIL ready_in_write observed=%0b expected=0", bus.byte_ready_o);
            end
        end
    end

    logic [7:0]  stim[$];
    int          acc_cyc[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done, exp_err;
    int          exp_words;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference model: derives the stream and expected outcome from the length rules.
    task automatic build(input int len, input logic [7:0] data[$], input bit bad_sum);
        logic [7:0] sum;
        sum = 8'h00;
        stim.delete();
        exp_addr.delete();
        exp_data.delete();
        stim.push_back(len[7:0]);
        stim.push_back(len[15:8]);
        if (len == 0) begin
            exp_done = 1; exp_err = 0; exp_words = 0;
        end else if (len > MEM_SIZE) begin
            exp_done = 0; exp_err = 1; exp_words = 0;
        end else begin
            for (int i = 0; i < len * 4; i++) begin
                stim.push_back(data[i]);
                sum = sum ^ data[i];
            end
            for (int w = 0; w < len; w++) begin
                exp_addr.push_back(32'(w * 4));
                exp_data.push_back({data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]});
            end
            exp_words = len;
            exp_done  = 1; exp_err = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            stim.push_back(bad_sum ? (sum ^ 8'h01) : sum);
            if (bad_sum) begin exp_done = 0; exp_err = 1; end
`endif
        end
    endtask

    task automatic send(input int gap_pct, input bit inject_start);
        int idx = 0;
        int budget = 0;
        bit injected = 0;
        acc_cyc.delete();
        while (idx < stim.size() && budget < 20000) begin
            @(negedge clk);
            budget++;
            bus.byte_i       = stim[idx];
            bus.byte_valid_i = ($urandom_range(99) >= gap_pct);
            start = 1'b0;
            if (inject_start && !injected && idx == 3) begin
                start = 1'b1;
                injected = 1;
            end
            if (bus.byte_valid_i && bus.byte_ready_o) begin
                acc_cyc.push_back(cyc + 1);
                idx++;
            end
        end
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        start = 1'b0;
        chk("stream_consumed", idx, stim.size());
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("end_reached", done | error, 1);
    endtask

    task automatic run_and_check(input string tag, input int len, input logic [7:0] data[$],
                                 input int gap_pct, input bit inject_start, input bit bad_sum);
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
        build(len, data, bad_sum);
        start_pulse();
        chk({tag, "_start_busy"}, {busy, cpu_hold, done, error}, 4'b1100);
        chk({tag, "_start_words"}, words_loaded, 0);
        send(gap_pct, inject_start);
        wait_end();
        chk({tag, "_nwrites"}, cap_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), cap_addr[i], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), cap_data[i], exp_data[i]);
            if (2 + 4 * i + 3 < acc_cyc.size())
                chk($sformatf("%s_lat%0d", tag, i), cap_cyc[i], acc_cyc[2 + 4 * i + 3]);
        end
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_hold"}, cpu_hold, exp_err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_words"}, words_loaded, exp_words);
        if (exp_addr.size() > 0) begin
            chk({tag, "_addr_hold"}, bus.mem_addr_o, exp_addr[exp_addr.size() - 1]);
            chk({tag, "_data_hold"}, bus.mem_wdata_o, exp_data[exp_data.size() - 1]);
        end
    endtask

    logic [7:0] fixed[$];
    logic [7:0] rnd[$];
    logic [7:0] none[$];
    int         len;

    initial begin
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        fixed = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        none.delete();

        repeat (3) @(negedge clk);
        chk("rst_status", {cpu_hold, busy, done, error, bus.byte_ready_o, bus.mem_we_o}, 6'b0);
        chk("rst_addr", bus.mem_addr_o, 0);
        chk("rst_data", bus.mem_wdata_o, 0);
        chk("rst_words", words_loaded, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", bus.byte_ready_o, 0);

        run_and_check("normal", 2, fixed, 0, 0, 0);

`ifndef IMEM_LOADER_CHECKSUM_EN
        // trailing byte after DONE must stay unconsumed
        @(negedge clk);
        bus.byte_i = 8'hB6;
        bus.byte_valid_i = 1'b1;
        chk("trail_ready", bus.byte_ready_o, 0);
        repeat (3) @(negedge clk);
        bus.byte_valid_i = 1'b0;
        chk("trail_done", {done, error, busy}, 3'b100);
        chk("trail_words", words_loaded, 2);
`endif

        run_and_check("zero_len", 0, none, 0, 0, 0);
        run_and_check("oversize", 257, none, 0, 0, 0);
        run_and_check("bubbles", 2, fixed, 50, 0, 0);

        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(8, 1);
            rnd.delete();
            for (int i = 0; i < len * 4; i++) rnd.push_back(8'($urandom));
            run_and_check($sformatf("rand%0d", k), len, rnd, $urandom_range(70, 0), k == 2, 0);
        end

        len = $urandom_range(65535, 257);
        run_and_check("rand_over", len, none, 20, 0, 0);

        rnd.delete();
        for (int i = 0; i < MEM_SIZE * 4; i++) rnd.push_back(8'($urandom));
        run_and_check("max_len", MEM_SIZE, rnd, 0, 0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        rnd = '{8'h13, 8'h05, 8'hA0, 8'h00};
        run_and_check("sum_good", 1, rnd, 0, 0, 0);
        chk("sum_good_byte", stim[6], 8'hB6);
        run_and_check("sum_bad", 1, rnd, 30, 0, 1);
        chk("sum_bad_byte", stim[6], 8'hB7);
`endif

        // reset in the middle of a load, after two data bytes
        stim = '{8'h02, 8'h00, 8'h13, 8'h05};
        start_pulse();
        send(0, 0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_status", {cpu_hold, busy, done, error, bus.byte_ready_o, bus.mem_we_o}, 6'b0);
        chk("midrst_addr", bus.mem_addr_o, 0);
        chk("midrst_data", bus.mem_wdata_o, 0);
        chk("midrst_words", words_loaded, 0);
        @(negedge clk);
        rst = 1'b1;
        run_and_check("after_rst", 2, fixed, 25, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
